// File: rtl/alu_seq_pkg.sv
// Shared definitions for the ALU operation sequencer: FSM state codes,
// ALU opcode constants and the width of one captured result entry.
package alu_seq_pkg;

  // Sequencer FSM state encoding (3 bits)
  localparam logic [2:0] IDLE       = 3'd0;
  localparam logic [2:0] WAIT_READY = 3'd1;
  localparam logic [2:0] ISSUE      = 3'd2;
  localparam logic [2:0] WAIT_DONE  = 3'd3;
  localparam logic [2:0] NEXT       = 3'd4;
  localparam logic [2:0] FINISH     = 3'd5;
  localparam logic [2:0] ERROR      = 3'd6;

  // ALU opcodes, same numbering as fsm_alu
  localparam logic [2:0] OP_0 = 3'd0;
  localparam logic [2:0] OP_1 = 3'd1;
  localparam logic [2:0] OP_2 = 3'd2;
  localparam logic [2:0] OP_3 = 3'd3;
  localparam logic [2:0] OP_4 = 3'd4;
  localparam logic [2:0] OP_5 = 3'd5;
  localparam logic [2:0] OP_6 = 3'd6;
  localparam logic [2:0] OP_7 = 3'd7;

  // One result-file entry holds {cout, result[4:0]}
  localparam int ENTRY_W = 6;

  // Opcode walk step; 3-bit arithmetic so 7 wraps to 0
  function automatic logic [2:0] next_op(input logic [2:0] op);
    return op + 3'd1;
  endfunction

endpackage

// File: rtl/alu_seq_timeout.sv
// Wait-state watchdog for the sequencer. The counter is held at zero while
// clr is high and counts cycles while en is high. expired flags the cycle
// that is the TIMEOUT-th one spent waiting, so the FSM leaves on the edge
// that ends that cycle.
module alu_seq_timeout #(
  parameter int TIMEOUT = 15,
  parameter int TCW     = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam logic [TCW-1:0] LAST = TCW'(TIMEOUT - 1);
  localparam logic [TCW-1:0] ONE  = TCW'(1);

  logic [TCW-1:0] cnt;

  // Cycle counter: cleared outside the wait states, counts inside them
  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + ONE;
    end
  end

  assign expired = en && (cnt == LAST);

endmodule

// File: rtl/alu_op_sequencer.sv
// Command-side initiator for the 4-bit FSM ALU. On start it latches one
// operand pair and an opcode range, then for each opcode waits for ALU
// ready, pulses go, waits for done and stores {cout,result} in a small
// result file indexed by opcode.
//
// Handshake with the ALU: a command is issued only after alu_ready was seen
// high in WAIT_READY; alu_go is then high for exactly one cycle (ISSUE) with
// alu_opcode/alu_a/alu_b stable, and the result is taken on the first cycle
// alu_done is high in WAIT_DONE. alu_done outside WAIT_DONE is ignored.
module alu_op_sequencer
  import alu_seq_pkg::*;
#(
  parameter int TIMEOUT = 15,
  parameter int TCW     = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [3:0]   a_in,
  input  logic [3:0]   b_in,
  input  logic [2:0]   op_first,
  input  logic [2:0]   op_last,
  input  logic         alu_ready,
  input  logic         alu_done,
  input  logic [4:0]   alu_result,
  input  logic         alu_cout,
  output logic [2:0]   alu_opcode,
  output logic [3:0]   alu_a,
  output logic [3:0]   alu_b,
  output logic         alu_go,
  output logic         busy,
  output logic         done,
  output logic         error,
  input  logic [2:0]   rd_addr,
  output logic [5:0]   rd_data,
  output logic         rd_valid,
  output logic [2:0]   dbg_state
);

  logic [2:0]         state;
  logic [2:0]         state_nxt;
  logic [2:0]         cur_op;
  logic [2:0]         last_op;
  logic [7:0]         valid;
  logic [ENTRY_W-1:0] entries [8];
  logic               tmo_clr;
  logic               tmo_expired;
  logic               accept;
  logic               capture;

  assign accept  = (state == IDLE) && start;
  assign capture = (state == WAIT_DONE) && alu_done;

  // The watchdog only runs in the two wait states; leaving them clears it,
  // so every entry into a wait state starts from zero.
  assign tmo_clr = !((state == WAIT_READY) || (state == WAIT_DONE));

  alu_seq_timeout #(
    .TIMEOUT (TIMEOUT),
    .TCW     (TCW)
  ) u_timeout (
    .clk     (clk),
    .reset   (reset),
    .clr     (tmo_clr),
    .en      (!tmo_clr),
    .expired (tmo_expired)
  );

  // Next-state logic; ready wins over a simultaneous done in WAIT_READY
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:       if (start) state_nxt = WAIT_READY;
      WAIT_READY: begin
        if (alu_ready)        state_nxt = ISSUE;
        else if (tmo_expired) state_nxt = ERROR;
      end
      ISSUE:      state_nxt = WAIT_DONE;
      WAIT_DONE:  begin
        if (alu_done)         state_nxt = NEXT;
        else if (tmo_expired) state_nxt = ERROR;
      end
      NEXT:       state_nxt = (cur_op == last_op) ? FINISH : WAIT_READY;
      FINISH:     state_nxt = IDLE;
      ERROR:      state_nxt = IDLE;
      default:    state_nxt = IDLE;
    endcase
  end

  // FSM state, latched run parameters, opcode walk and sticky error flag
  always_ff @(posedge clk) begin
    if (!reset) begin
      state   <= IDLE;
      cur_op  <= OP_0;
      last_op <= OP_0;
      alu_a   <= '0;
      alu_b   <= '0;
      error   <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        alu_a   <= a_in;
        alu_b   <= b_in;
        cur_op  <= op_first;
        last_op <= op_last;
        error   <= 1'b0;
      end
      if ((state == NEXT) && (cur_op != last_op)) begin
        cur_op <= next_op(cur_op);
      end
      if (state_nxt == ERROR) begin
        error <= 1'b1;
      end
    end
  end

  // Result file: valid bits drop on every accepted start, entries are
  // overwritten as results arrive (stale data stays behind a clear valid)
  always_ff @(posedge clk) begin
    if (!reset) begin
      valid <= '0;
      for (int i = 0; i < 8; i++) begin
        entries[i] <= '0;
      end
    end else begin
      if (accept) begin
        valid <= '0;
      end
      if (capture) begin
        entries[cur_op] <= {alu_cout, alu_result};
        valid[cur_op]   <= 1'b1;
      end
    end
  end

  assign alu_opcode = cur_op;
  assign alu_go     = (state == ISSUE);
  assign busy       = (state != IDLE);
  assign done       = (state == FINISH);
  assign dbg_state  = state;
  assign rd_data    = entries[rd_addr];
  assign rd_valid   = valid[rd_addr];

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Bench for alu_op_sequencer: a behavioural ALU responder, a table of
// directed runs with hand-computed result files, and hand-written sequences
// for reset mid-run, timeout, start-while-busy and spurious done.
module tb_alu_op_sequencer;
  import alu_seq_pkg::*;

  typedef struct {
    logic [3:0]  a;
    logic [3:0]  b;
    logic [2:0]  first;
    logic [2:0]  last;
    logic [7:0]  mask;
    logic [47:0] data;   // {entry7, ..., entry0}, 6 bits each
  } vec_t;

  logic       clk;
  logic       reset;
  logic       start;
  logic [3:0] a_in, b_in;
  logic [2:0] op_first, op_last;
  logic       alu_ready, alu_done, alu_cout;
  logic [4:0] alu_result;
  logic [2:0] alu_opcode;
  logic [3:0] alu_a, alu_b;
  logic       alu_go, busy, done, error;
  logic [2:0] rd_addr;
  logic [5:0] rd_data;
  logic       rd_valid;
  logic [2:0] dbg_state;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  logic [2:0] exp_q[$];
  int         go_cyc_log[$];
  logic [3:0] exp_a, exp_b;
  int         done_cnt = 0;
  int         pend_cnt = 0;
  logic       model_mute, model_spur;
  vec_t       vecs[5];

  alu_op_sequencer #(.TIMEOUT(15), .TCW(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .a_in       (a_in),
    .b_in       (b_in),
    .op_first   (op_first),
    .op_last    (op_last),
    .alu_ready  (alu_ready),
    .alu_done   (alu_done),
    .alu_result (alu_result),
    .alu_cout   (alu_cout),
    .alu_opcode (alu_opcode),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_go     (alu_go),
    .busy       (busy),
    .done       (done),
    .error      (error),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .rd_valid   (rd_valid),
    .dbg_state  (dbg_state)
  );

  // Clock and cycle counter
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  // Behavioural ALU: parity of the result goes out on cout
  function automatic logic [5:0] alu_fn(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b);
    logic [4:0] r;
    case (op)
      3'd0:    r = {1'b0, a} + {1'b0, b};
      3'd1:    r = {1'b0, a} - {1'b0, b};
      3'd2:    r = {1'b0, a & b};
      3'd3:    r = {1'b0, a | b};
      3'd4:    r = {1'b0, a ^ b};
      3'd5:    r = {1'b0, ~a};
      3'd6:    r = {a, 1'b0};
      default: r = {1'b0, a} + {1'b0, b} + 5'd1;
    endcase
    return {^r, r};
  endfunction

  function automatic vec_t mk(input logic [3:0] a, input logic [3:0] b, input logic [2:0] f,
                              input logic [2:0] l, input logic [7:0] m, input logic [47:0] d);
    vec_t v;
    v.a = a; v.b = b; v.first = f; v.last = l; v.mask = m; v.data = d;
    return v;
  endfunction

  // ALU responder and go/done monitor; done arrives 2 cycles after go
  logic [2:0] cap_op;
  logic [3:0] cap_a, cap_b;
  initial begin
    alu_ready = 1'b1; alu_done = 1'b0; alu_result = '0; alu_cout = 1'b0;
    forever begin
      @(negedge clk);
      if (done) done_cnt++;
      if (alu_go && pend_cnt != 0) check("go_while_alu_busy", 1, 0);
      alu_done = 1'b0;
      if (pend_cnt != 0) begin
        pend_cnt--;
        if (pend_cnt == 0) begin
          {alu_cout, alu_result} = alu_fn(cap_op, cap_a, cap_b);
          alu_done  = !model_mute;
          alu_ready = 1'b1;
        end
      end else if (alu_go) begin
        go_cyc_log.push_back(cyc);
        if (exp_q.size() > 0) check("go_opcode", alu_opcode, exp_q.pop_front());
        else check("go_extra_pulse", 1, 0);
        check("go_alu_a", alu_a, exp_a);
        check("go_alu_b", alu_b, exp_b);
        cap_op = alu_opcode; cap_a = alu_a; cap_b = alu_b;
        alu_ready = 1'b0;
        pend_cnt  = 2;
      end else if (model_spur) begin
        alu_done = 1'b1; alu_result = 5'h1f; alu_cout = 1'b1;
      end
    end
  end

  int start_cyc, go_base, done_base;

  // Driver: queue the expected opcode walk and pulse start for one cycle
  task automatic launch(input logic [3:0] a, input logic [3:0] b, input logic [2:0] f, input logic [2:0] l);
    logic [2:0] op;
    while (pend_cnt != 0) @(negedge clk);
    op = f;
    for (int k = 0; k < 8; k++) begin
      exp_q.push_back(op);
      if (op == l) break;
      op = op + 3'd1;
    end
    exp_a = a; exp_b = b;
    go_base = go_cyc_log.size();
    done_base = done_cnt;
    a_in = a; b_in = b; op_first = f; op_last = l;
    start = 1'b1;
    start_cyc = cyc;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Wait for the run to end, then check handshake totals and the result file
  task automatic finish_check(input logic [7:0] mask, input logic [47:0] data, input string tag);
    int n;
    n = 0;
    while (busy && n < 400) begin
      @(negedge clk);
      n++;
    end
    check($sformatf("%s_busy_end", tag), busy, 0);
    check($sformatf("%s_done_pulses", tag), done_cnt - done_base, 1);
    check($sformatf("%s_error", tag), error, 0);
    check($sformatf("%s_ops_missing", tag), exp_q.size(), 0);
    if (go_cyc_log.size() > go_base)
      check($sformatf("%s_first_go_latency", tag), go_cyc_log[go_base] - start_cyc, 2);
    else
      check($sformatf("%s_first_go_seen", tag), 0, 1);
    exp_q.delete();
    for (int i = 0; i < 8; i++) begin
      rd_addr = 3'(i);
      #1;
      check($sformatf("%s_rd_valid[%0d]", tag, i), rd_valid, mask[i]);
      if (mask[i]) check($sformatf("%s_rd_data[%0d]", tag, i), rd_data, data[i*6 +: 6]);
    end
  endtask

  // Main sequence
  initial begin
    int n;
    int t0;
    reset = 1'b0; start = 1'b0; a_in = '0; b_in = '0; op_first = '0; op_last = '0;
    rd_addr = '0; model_mute = 1'b0; model_spur = 1'b0;

    vecs[0] = mk(4'd9, 4'd9, 3'd0, 3'd0, 8'h01,
                 {6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h12});
    vecs[1] = mk(4'd9, 4'd9, 3'd0, 3'd7, 8'hff,
                 {6'h33, 6'h12, 6'h06, 6'h00, 6'h09, 6'h09, 6'h00, 6'h12});
    vecs[2] = mk(4'd5, 4'd3, 3'd6, 3'd1, 8'hc3,
                 {6'h09, 6'h0a, 6'h00, 6'h00, 6'h00, 6'h00, 6'h22, 6'h28});
    vecs[3] = mk(4'd15, 4'd1, 3'd3, 3'd3, 8'h08,
                 {6'h00, 6'h00, 6'h00, 6'h00, 6'h0f, 6'h00, 6'h00, 6'h00});
    vecs[4] = mk(4'd15, 4'd1, 3'd7, 3'd0, 8'h81,
                 {6'h11, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h30});

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_state", dbg_state, IDLE);
    check("rst_alu_go", alu_go, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_error", error, 0);
    check("rst_alu_opcode", alu_opcode, 0);
    check("rst_alu_a", alu_a, 0);
    check("rst_alu_b", alu_b, 0);
    for (int i = 0; i < 8; i++) begin
      rd_addr = 3'(i);
      #1;
      check($sformatf("rst_rd_valid[%0d]", i), rd_valid, 0);
      check($sformatf("rst_rd_data[%0d]", i), rd_data, 0);
    end
    reset = 1'b1;
    @(negedge clk);

    // Table-driven runs
    for (int v = 0; v < 5; v++) begin
      launch(vecs[v].a, vecs[v].b, vecs[v].first, vecs[v].last);
      finish_check(vecs[v].mask, vecs[v].data, $sformatf("vec%0d", v));
      @(negedge clk);
    end

    // Start re-pulsed while busy, spurious done outside WAIT_DONE
    model_spur = 1'b1;
    launch(4'd9, 4'd9, 3'd0, 3'd2);
    a_in = 4'd1; b_in = 4'd2; op_first = 3'd5; op_last = 3'd5;
    start = 1'b1;
    repeat (4) @(negedge clk);
    start = 1'b0;
    finish_check(8'h07, {6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h09, 6'h00, 6'h12}, "busy_start");
    check("busy_start_hold_a", alu_a, 4'd9);
    check("busy_start_hold_b", alu_b, 4'd9);
    model_spur = 1'b0;
    @(negedge clk);

    // Timeout in WAIT_DONE
    model_mute = 1'b1;
    launch(4'd9, 4'd9, 3'd2, 3'd4);
    n = 0;
    while (dbg_state != WAIT_DONE && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("tmo_reach_wait_done", dbg_state, WAIT_DONE);
    t0 = cyc;
    n = 0;
    while (!error && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("tmo_error_set", error, 1);
    check("tmo_cycles", cyc - t0, 15);
    check("tmo_state_error", dbg_state, ERROR);
    check("tmo_done_low", done_cnt - done_base, 0);
    @(negedge clk);
    check("tmo_back_idle", dbg_state, IDLE);
    check("tmo_busy_low", busy, 0);
    check("tmo_error_sticky", error, 1);
    rd_addr = 3'd2;
    #1;
    check("tmo_no_capture", rd_valid, 0);
    exp_q.delete();
    model_mute = 1'b0;
    @(negedge clk);
    launch(4'd9, 4'd9, 3'd2, 3'd2);
    check("tmo_error_cleared", error, 0);
    finish_check(8'h04, {6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h09, 6'h00, 6'h00}, "post_tmo");
    @(negedge clk);

    // Reset held low for 2 cycles in WAIT_DONE, with captured entries present
    launch(4'd9, 4'd9, 3'd0, 3'd7);
    rd_addr = 3'd0;
    n = 0;
    while (!(rd_valid && dbg_state == WAIT_DONE) && n < 60) begin
      @(negedge clk);
      n++;
    end
    check("mid_rst_reach_wait_done", dbg_state, WAIT_DONE);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("mid_rst_state", dbg_state, IDLE);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_alu_go", alu_go, 0);
    check("mid_rst_alu_a", alu_a, 0);
    for (int i = 0; i < 8; i++) begin
      rd_addr = 3'(i);
      #1;
      check($sformatf("mid_rst_rd_valid[%0d]", i), rd_valid, 0);
    end
    exp_q.delete();
    repeat (4) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global time limit
  initial begin
    #200000;
    failures++;
    $display("FAIL watchdog actual=timeout required=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
